// File: rtl/pixel_block_cache_reader_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | pixel_block_cache_reader_if                                                 |
// | Request, pixel-quad output and DDR3 read-channel bundle for the block cache. |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
interface pixel_block_cache_reader_if #(
  parameter int PIX_W  = 16,
  parameter int ADDR_W = 25,
  parameter int FRAC_W = 16
);
  logic                in_valid;
  logic                in_ready;
  logic [ADDR_W-1:0]   in_addr;
  logic [15:0]         in_loca;
  logic [FRAC_W-1:0]   in_frac;

  logic                out_valid;
  logic                out_ready;
  logic [4*PIX_W-1:0]  out_pixels;
  logic [FRAC_W-1:0]   out_frac;

  logic                rd_ddr3_req;
  logic [9:0]          rd_ddr3_len;
  logic [ADDR_W-1:0]   rd_ddr3_addr;
  logic                rd_ddr3_ready;
  logic                rd_ddr3_data_valid;
  logic [4*PIX_W-1:0]  rd_ddr3_data;

  modport slave (
    input  in_valid, in_addr, in_loca, in_frac, out_ready,
           rd_ddr3_ready, rd_ddr3_data_valid, rd_ddr3_data,
    output in_ready, out_valid, out_pixels, out_frac,
           rd_ddr3_req, rd_ddr3_len, rd_ddr3_addr
  );

  modport master (
    output in_valid, in_addr, in_loca, in_frac, out_ready,
           rd_ddr3_ready, rd_ddr3_data_valid, rd_ddr3_data,
    input  in_ready, out_valid, out_pixels, out_frac,
           rd_ddr3_req, rd_ddr3_len, rd_ddr3_addr
  );
endinterface
`default_nettype wire

// File: rtl/pixel_block_cache_reader.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | pixel_block_cache_reader                                                    |
// | Fully-associative 4x4 pixel block cache feeding a bilinear filter quad.     |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module pixel_block_cache_reader #(
  parameter int PIX_W       = 16,
  parameter int ADDR_W      = 25,
  parameter int FRAC_W      = 16,
  parameter int CACHE_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cache_en,
  input  logic                            flush,
  pixel_block_cache_reader_if.slave       bus,
  output logic [31:0]                     hit_cnt,
  output logic [31:0]                     miss_cnt
);

  localparam int BEAT_W = 4*PIX_W;
  localparam int BLK_W  = 16*PIX_W;
  localparam int PTR_W  = (CACHE_DEPTH > 1) ? $clog2(CACHE_DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(CACHE_DEPTH-1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOOKUP   = 3'd1;
  localparam logic [2:0] S_MEM_REQ  = 3'd2;
  localparam logic [2:0] S_MEM_FILL = 3'd3;
  localparam logic [2:0] S_OUT      = 3'd4;

  logic [2:0]              state_q, state_d;
  logic [ADDR_W-1:0]       addr_q;
  logic [15:0]             loca_q;
  logic [FRAC_W-1:0]       frac_q;
  logic [CACHE_DEPTH-1:0]  valid_q;
  logic [ADDR_W-1:0]       tag_q  [CACHE_DEPTH];
  logic [BLK_W-1:0]        data_q [CACHE_DEPTH];
  logic [PTR_W-1:0]        ptr_q;
  logic                    alloc_q, flushed_q, req_q;
  logic [1:0]              beat_q;
  logic [3*BEAT_W-1:0]     buf_q;
  logic [4*PIX_W-1:0]      pix_q;
  logic [FRAC_W-1:0]       ofrac_q;
  logic [31:0]             hit_q, miss_q;

  logic                    lookup_hit;
  logic [PTR_W-1:0]        hit_idx;
  logic                    issue, last_beat, fill_wr;
  logic [BLK_W-1:0]        fill_block, src_block;
  logic [4*PIX_W-1:0]      quad;

  function automatic logic [PIX_W-1:0] pick(input logic [BLK_W-1:0] blk, input logic [3:0] idx);
    return blk[int'(idx)*PIX_W +: PIX_W];
  endfunction

  // Descending scan so the lowest matching entry wins; a flush in the same cycle forces a miss.
  always_comb begin
    lookup_hit = 1'b0;
    hit_idx    = '0;
    for (int i = CACHE_DEPTH-1; i >= 0; i--) begin
      if (valid_q[i] && (tag_q[i] == addr_q)) begin
        lookup_hit = 1'b1;
        hit_idx    = PTR_W'(i);
      end
    end
    lookup_hit = lookup_hit & cache_en & ~flush;
  end

  assign issue      = (((state_q == S_LOOKUP) && !lookup_hit) || (state_q == S_MEM_REQ))
                      && bus.rd_ddr3_ready;
  assign last_beat  = (state_q == S_MEM_FILL) && bus.rd_ddr3_data_valid && (beat_q == 2'd3);
  assign fill_wr    = last_beat && alloc_q && cache_en;
  assign fill_block = {bus.rd_ddr3_data, buf_q};
  assign src_block  = (state_q == S_LOOKUP) ? data_q[hit_idx] : fill_block;
  assign quad       = {pick(src_block, loca_q[15:12]), pick(src_block, loca_q[11:8]),
                       pick(src_block, loca_q[7:4]),   pick(src_block, loca_q[3:0])};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (bus.in_valid) state_d = S_LOOKUP;
      S_LOOKUP:   if (lookup_hit) state_d = S_OUT;
                  else if (bus.rd_ddr3_ready) state_d = S_MEM_FILL;
                  else state_d = S_MEM_REQ;
      S_MEM_REQ:  if (bus.rd_ddr3_ready) state_d = S_MEM_FILL;
      S_MEM_FILL: if (last_beat) state_d = S_OUT;
      S_OUT:      if (bus.out_ready) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == S_IDLE);
    bus.out_valid = (state_q == S_OUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      loca_q    <= '0;
      frac_q    <= '0;
      valid_q   <= '0;
      ptr_q     <= '0;
      alloc_q   <= 1'b0;
      flushed_q <= 1'b0;
      req_q     <= 1'b0;
      beat_q    <= '0;
      buf_q     <= '0;
      pix_q     <= '0;
      ofrac_q   <= '0;
      hit_q     <= '0;
      miss_q    <= '0;
    end else begin
      if ((state_q == S_IDLE) && bus.in_valid) begin
        addr_q <= bus.in_addr;
        loca_q <= bus.in_loca;
        frac_q <= bus.in_frac;
      end
      if ((state_q == S_LOOKUP) && lookup_hit) begin
        pix_q   <= quad;
        ofrac_q <= frac_q;
        hit_q   <= hit_q + 32'd1;
      end
      if (issue) begin
        req_q     <= 1'b1;
        miss_q    <= miss_q + 32'd1;
        beat_q    <= '0;
        alloc_q   <= cache_en;
        flushed_q <= 1'b0;
      end
      if (state_q == S_MEM_FILL) begin
        if (flush) flushed_q <= 1'b1;
        if (bus.rd_ddr3_data_valid) begin
          req_q  <= 1'b0;
          beat_q <= beat_q + 2'd1;
          buf_q  <= {bus.rd_ddr3_data, buf_q[3*BEAT_W-1:BEAT_W]};
          if (beat_q == 2'd3) begin
            pix_q   <= quad;
            ofrac_q <= frac_q;
          end
        end
      end
      if (fill_wr) ptr_q <= (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
      // The victim is invalidated at issue so a stale block can never hit mid-fill.
      if (flush) begin
        valid_q <= '0;
      end else begin
        if (issue && cache_en) valid_q[ptr_q] <= 1'b0;
        if (fill_wr && !flushed_q) valid_q[ptr_q] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_wr) begin
      tag_q[ptr_q]  <= addr_q;
      data_q[ptr_q] <= fill_block;
    end
  end

  assign bus.out_pixels   = pix_q;
  assign bus.out_frac     = ofrac_q;
  assign bus.rd_ddr3_req  = req_q;
  assign bus.rd_ddr3_addr = addr_q;
  assign bus.rd_ddr3_len  = 10'd4;
  assign hit_cnt          = hit_q;
  assign miss_cnt         = miss_q;

endmodule
`default_nettype wire
